// File: rtl/twist_monitor.sv
`default_nettype none
// ---------------------------------------------------------------------------
// twist_monitor : Johnson-code stream checker (decode, legality, order, lock)
// Rev 1.0
// ---------------------------------------------------------------------------
module twist_monitor #(
    parameter int WIDTH     = 8,
    parameter int LOCK_CNT  = 4,
    parameter int ERR_LIMIT = 3,
    localparam int IW       = $clog2(2*WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] code_in,
    input  logic             code_vld,
    output logic [IW-1:0]    idx,
    output logic             idx_vld,
    output logic             illegal,
    output logic             seq_err,
    output logic             locked,
    output logic [7:0]       err_cnt
);

    localparam int GW   = $clog2(LOCK_CNT+1);
    localparam int BW   = $clog2(ERR_LIMIT+1);
    localparam int LAST = 2*WIDTH-1;

    typedef enum logic [0:0] {
        HUNT = 1'b0,
        LOCK = 1'b1
    } state_t;

    state_t          state_q;
    logic [IW-1:0]   idx_q;
    logic [IW-1:0]   prev_q;
    logic            have_prev_q;
    logic            idx_vld_q;
    logic            illegal_q;
    logic            seq_err_q;
    logic [7:0]      err_q;
    logic [GW-1:0]   good_q;
    logic [BW-1:0]   bad_q;

    function automatic logic [IW-1:0] popcnt(input logic [WIDTH-1:0] v);
        logic [IW-1:0] n;
        n = '0;
        for (int i = 0; i < WIDTH; i++) begin
            n = n + IW'(v[i]);
        end
        return n;
    endfunction

    // Complementing words with MSB set folds both halves of the sequence
    // onto one thermometer shape, so one check covers legality.
    logic [WIDTH-1:0] norm;
    logic             code_legal;
    logic [IW-1:0]    dec_idx;
    logic [IW-1:0]    next_exp;
    logic             seq_bad;
    logic [GW-1:0]    good_d;
    logic [BW-1:0]    bad_d;
    logic [7:0]       err_d;

    assign norm       = code_in[WIDTH-1] ? ~code_in : code_in;
    assign code_legal = ((norm & (norm + WIDTH'(1))) == '0);
    assign dec_idx    = code_in[WIDTH-1] ? (IW'(WIDTH) + popcnt(norm)) : popcnt(norm);
    assign next_exp   = (prev_q == IW'(LAST)) ? '0 : (prev_q + IW'(1));
    assign seq_bad    = have_prev_q && (dec_idx != next_exp);
    assign good_d     = (!have_prev_q || seq_bad) ? GW'(1) : (good_q + GW'(1));
    assign bad_d      = bad_q + BW'(1);
    assign err_d      = (err_q == 8'hFF) ? err_q : (err_q + 8'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= HUNT;
            idx_q       <= '0;
            prev_q      <= '0;
            have_prev_q <= 1'b0;
            idx_vld_q   <= 1'b0;
            illegal_q   <= 1'b0;
            seq_err_q   <= 1'b0;
            err_q       <= '0;
            good_q      <= '0;
            bad_q       <= '0;
        end else begin
            idx_vld_q <= 1'b0;
            illegal_q <= 1'b0;
            seq_err_q <= 1'b0;
            if (code_vld) begin
                if (!code_legal) begin
                    illegal_q <= 1'b1;
                    err_q     <= err_d;
                    if (state_q == HUNT) begin
                        good_q      <= '0;
                        have_prev_q <= 1'b0;
                    end else if (bad_d == BW'(ERR_LIMIT)) begin
                        state_q     <= HUNT;
                        good_q      <= '0;
                        have_prev_q <= 1'b0;
                    end else begin
                        bad_q <= bad_d;
                    end
                end else begin
                    idx_q       <= dec_idx;
                    idx_vld_q   <= 1'b1;
                    seq_err_q   <= seq_bad;
                    prev_q      <= dec_idx;
                    have_prev_q <= 1'b1;
                    if (seq_bad) begin
                        err_q <= err_d;
                    end
                    if (state_q == HUNT) begin
                        good_q <= good_d;
                        if (good_d == GW'(LOCK_CNT)) begin
                            state_q <= LOCK;
                            bad_q   <= '0;
                        end
                    end else if (seq_bad) begin
                        // Later have_prev_q assignment wins: losing lock drops the reference
                        if (bad_d == BW'(ERR_LIMIT)) begin
                            state_q     <= HUNT;
                            good_q      <= '0;
                            have_prev_q <= 1'b0;
                        end else begin
                            bad_q <= bad_d;
                        end
                    end else begin
                        bad_q <= '0;
                    end
                end
            end
        end
    end

    assign idx     = idx_q;
    assign idx_vld = idx_vld_q;
    assign illegal = illegal_q;
    assign seq_err = seq_err_q;
    assign locked  = (state_q == LOCK);
    assign err_cnt = err_q;

endmodule
`default_nettype wire
